// File: rtl/seven_seg_scan_driver_if.sv
// Bus bundle between a register/debug source and the seven-segment scan driver.
// The master side presents digit data and the load strobe; the slave side
// (the driver) returns the multiplexed segment, decimal point and anode lines.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] numin;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lz_en;
  logic                    load;
  logic [6:0]              segout;
  logic                    dpout;
  logic [NUM_DIGITS-1:0]   anode;

  modport master (
    output numin, dp_in, blank_in, lz_en, load,
    input  segout, dpout, anode
  );

  modport slave (
    input  numin, dp_in, blank_in, lz_en, load,
    output segout, dpout, anode
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// N-digit common-anode seven-segment scan driver.
// One shared, active-low segment bus is time-multiplexed across per-digit
// active-low anode enables. Display data lives in a shadow copy captured on
// load, so the source registers may change freely between loads. Each digit
// slot starts with a few all-dark cycles to keep the previous digit's segment
// pattern from ghosting onto the next anode. All outputs are registered.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  seven_seg_scan_driver_if.slave bus
);

  // Counter widths; the index keeps at least one bit even for a single digit.
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam bit            HAS_DEAD   = (DEAD_CYC > 0);

  localparam logic [6:0] SEG_DARK = 7'b1111111;

  // Active-low a..g pattern for one hex nibble ([6]=a ... [0]=g).
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Shadow copy of the display data
  logic [4*NUM_DIGITS-1:0] sh_num_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic [NUM_DIGITS-1:0]   sh_blank_r;
  logic                    sh_lz_r;

  // Scan position
  logic [PW-1:0] presc_r;
  logic [IW-1:0] idx_r;

  // Registered pin drivers
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [NUM_DIGITS-1:0] anode_r;

  // Next-state view of the pins
  logic                  dead_s;
  logic                  zero_run_s;
  logic [NUM_DIGITS-1:0] supp_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blank_s;
  logic                  cur_supp_s;
  logic [6:0]            seg_nx_s;
  logic                  dp_nx_s;
  logic [NUM_DIGITS-1:0] anode_nx_s;

  // Capture display data on load; reset clears it, and reset beats load.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sh_num_r   <= '0;
      sh_dp_r    <= '0;
      sh_blank_r <= '0;
      sh_lz_r    <= 1'b0;
    end else if (bus.load) begin
      sh_num_r   <= bus.numin;
      sh_dp_r    <= bus.dp_in;
      sh_blank_r <= bus.blank_in;
      sh_lz_r    <= bus.lz_en;
    end else begin
      sh_num_r   <= sh_num_r;
      sh_dp_r    <= sh_dp_r;
      sh_blank_r <= sh_blank_r;
      sh_lz_r    <= sh_lz_r;
    end
  end

  // Slot timer: counts cycles within the current digit slot and wraps.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit index: steps to the next digit whenever the slot timer wraps.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Leading-zero mask: a digit above 0 is suppressed while it and every
  // more-significant digit hold zero; the run breaks at the first non-zero.
  always_comb begin
    zero_run_s = 1'b1;
    supp_s     = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_s = zero_run_s & (sh_num_r[4*k +: 4] == 4'h0);
      if (k > 0) begin
        supp_s[k] = sh_lz_r & zero_run_s;
      end else begin
        supp_s[k] = 1'b0;
      end
    end
  end

  // Select the active digit's shadow fields and its anode enable.
  always_comb begin
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blank_s = 1'b0;
    cur_supp_s  = 1'b0;
    anode_nx_s  = {NUM_DIGITS{1'b1}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_r == IW'(k)) begin
        cur_nib_s     = sh_num_r[4*k +: 4];
        cur_dp_s      = sh_dp_r[k];
        cur_blank_s   = sh_blank_r[k];
        cur_supp_s    = supp_s[k];
        anode_nx_s[k] = 1'b0;
      end else begin
        anode_nx_s[k] = 1'b1;
      end
    end
  end

  // Compose the next pin values: dark during dead time, otherwise the glyph,
  // with blanking killing everything and suppression sparing only the dp.
  always_comb begin
    seg_nx_s = SEG_DARK;
    dp_nx_s  = 1'b1;
    if (HAS_DEAD) begin
      dead_s = (presc_r < DEAD_LIM);
    end else begin
      dead_s = 1'b0;
    end
    if (dead_s) begin
      seg_nx_s = SEG_DARK;
      dp_nx_s  = 1'b1;
    end else begin
      if (cur_blank_s || cur_supp_s) begin
        seg_nx_s = SEG_DARK;
      end else begin
        seg_nx_s = hex_glyph(cur_nib_s);
      end
      if (cur_blank_s) begin
        dp_nx_s = 1'b1;
      end else begin
        dp_nx_s = ~cur_dp_s;
      end
    end
  end

  // Register the pins; anodes are forced off during dead time and reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      seg_r   <= SEG_DARK;
      dp_r    <= 1'b1;
      anode_r <= {NUM_DIGITS{1'b1}};
    end else if (dead_s) begin
      seg_r   <= SEG_DARK;
      dp_r    <= 1'b1;
      anode_r <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r   <= seg_nx_s;
      dp_r    <= dp_nx_s;
      anode_r <= anode_nx_s;
    end
  end

  assign bus.segout = seg_r;
  assign bus.dpout  = dp_r;
  assign bus.anode  = anode_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (4 digits, 4-cycle slots,
// 1 dead cycle). A reference model derives every expected pin value from the
// elapsed cycle count since reset and a copy of the loaded display data.
module tb_seven_seg_scan_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(R),
    .DEAD_CYC   (D)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  // Free-running clock
  always #5 Clk = ~Clk;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: loaded data and cycles elapsed since the last reset edge
  logic [15:0] m_num   = 16'h0;
  logic [3:0]  m_dp    = 4'h0;
  logic [3:0]  m_blk   = 4'h0;
  logic        m_lz    = 1'b0;
  int          m_pos   = 0;
  bit          m_valid = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (model pos %0d)", tag, got, exp, m_pos);
    end
  endtask

  // Expected pins for the output word produced from model position m_pos.
  task automatic predict(output logic [6:0] seg, output logic dp, output logic [3:0] an);
    int         k;
    bit         supp;
    logic [3:0] nib;
    if ((m_pos % R) < D) begin
      seg = 7'h7F;
      dp  = 1'b1;
      an  = 4'hF;
    end else begin
      k      = (m_pos / R) % N;
      an     = 4'hF;
      an[k]  = 1'b0;
      nib    = 4'(m_num >> (4 * k));
      supp   = m_lz && (k > 0) && ((m_num >> (4 * k)) == 16'h0);
      seg    = (m_blk[k] || supp) ? 7'h7F : glyph_tab[nib];
      dp     = m_blk[k] ? 1'b1 : ~m_dp[k];
    end
  endtask

  // Drive one cycle of inputs, check the resulting pins, advance the model.
  task automatic step(input logic rst, input logic ld, input logic [15:0] num,
                      input logic [3:0] dpv, input logic [3:0] blk, input logic lz,
                      input string tag);
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    Rst          = rst;
    bus.load     = ld;
    bus.numin    = num;
    bus.dp_in    = dpv;
    bus.blank_in = blk;
    bus.lz_en    = lz;
    if (rst) begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = 4'hF;
    end else begin
      predict(e_seg, e_dp, e_an);
    end
    @(posedge Clk);
    #1;
    if (rst || m_valid) begin
      check_val({tag, "_seg"},   {9'h0, bus.segout}, {9'h0, e_seg});
      check_val({tag, "_dp"},    {15'h0, bus.dpout}, {15'h0, e_dp});
      check_val({tag, "_anode"}, {12'h0, bus.anode}, {12'h0, e_an});
    end
    if (rst) begin
      m_valid = 1'b1;
      m_pos   = 0;
      m_num   = 16'h0;
      m_dp    = 4'h0;
      m_blk   = 4'h0;
      m_lz    = 1'b0;
    end else begin
      m_pos++;
      if (ld) begin
        m_num = num;
        m_dp  = dpv;
        m_blk = blk;
        m_lz  = lz;
      end
    end
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), tag);
    end
  endtask

  initial begin
    logic [15:0] r_num;
    bit          r_rst;
    bit          r_ld;

    // Reset and a few cycles out of reset with empty shadow
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, "reset");
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0, 1'b0, "reset_ld");
    idle(6, "post_reset");

    // Basic scan of 1A2F
    step(1'b0, 1'b1, 16'h1A2F, 4'h0, 4'h0, 1'b0, "load_1a2f");
    idle(2 * N * R, "scan_1a2f");

    // Every glyph, held long enough to cover a full slot of digit 0
    for (int n = 0; n < 16; n++) begin
      step(1'b0, 1'b1, 16'(n), 4'h0, 4'h0, 1'b0, "glyph_ld");
      idle(N * R, "glyph");
    end

    // Leading-zero suppression
    step(1'b0, 1'b1, 16'h0040, 4'h0, 4'h0, 1'b1, "lz_ld");
    idle(N * R + 2, "lz_0040");
    step(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, "lz_ld0");
    idle(N * R + 2, "lz_0000");
    step(1'b0, 1'b1, 16'h0000, 4'b1000, 4'h0, 1'b1, "lz_dp_ld");
    idle(N * R + 2, "lz_dp");

    // Decimal point and blanking, with numin wandering but no load
    step(1'b0, 1'b1, 16'h5678, 4'b0100, 4'b0001, 1'b0, "dpblk_ld");
    idle(2 * N * R, "dpblk");

    // Load while digit 2 is in its second lit cycle
    for (int g = 0; g < 64 && (m_pos % (N * R)) != 2 * R + 2; g++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, "align2");
    end
    step(1'b0, 1'b1, 16'h9E3C, 4'h0, 4'h0, 1'b0, "midload");
    idle(N * R, "after_midload");

    // Reset together with load in the middle of digit 3's slot
    for (int g = 0; g < 64 && (m_pos % (N * R)) != 3 * R + 1; g++) begin
      step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0, "align3");
    end
    step(1'b1, 1'b1, 16'hBEEF, 4'hF, 4'h0, 1'b1, "rst_ld");
    idle(N * R, "after_rst");

    // Randomized traffic with occasional loads and resets
    for (int i = 0; i < 2000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_ld  = ($urandom_range(0, 7) == 0);
      r_num = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(r_rst, r_ld, r_num, 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           1'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Parametrised successor to the single-digit hex-to-seven-segment decoder.
- Drives an N-digit common-anode display by time-multiplexing one shared segment bus across per-digit anode enables.
- Adds full hex glyphs (A–F are no longer blanked), per-digit decimal point and blanking, optional leading-zero suppression, a double-buffered load, and inter-digit dead time against ghosting.
- Sits between processor/debug registers and the board's display pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
REFRESH_DIV, 100000, Clk cycles each digit is held (≥ 2)
DEAD_CYC, 2, cycles at the start of each digit slot with all anodes off (0 ≤ DEAD_CYC < REFRESH_DIV)

Ports:
Clk  in  1  system clock, all state on rising edge
Rst  in  1  synchronous active-high reset
numin  in  4*NUM_DIGITS  hex nibbles; digit k = numin[4k+3:4k], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_in  in  NUM_DIGITS  force digit dark, 1 = blank
lz_en  in  1  leading-zero suppression enable (sampled with load)
load  in  1  capture numin/dp_in/blank_in/lz_en into shadow registers
segout  out  7  segments, active-low, [6]=a … [0]=g
dpout  out  1  decimal point, active-low
anode  out  NUM_DIGITS  digit enables, active-low, at most one low at a time

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Rst).
- Reset values:
  - segout=7'b1111111, dpout=1, anode all 1.
  - Prescaler=0, digit index=0.
  - Shadow nibbles, dp, blank and lz all 0.
- Shadow load:
  - load=1 at an edge copies all inputs to the shadow.
  - The display uses only shadow values, so numin changes without load have no effect.
  - Load mid-slot takes effect on the active digit's outputs one cycle later; no slot restart.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At the wrap, the index advances; NUM_DIGITS-1 wraps to 0.
  - NUM_DIGITS=1: index stays 0; dead time still applies each slot.
- Registered outputs (one-cycle latency from prescaler/index/shadow state):
  - Prescaler < DEAD_CYC (dead time): anode all 1, segout all 1, dpout 1.
  - Otherwise: anode bit [index]=0 and the rest 1; segout=glyph(shadow nibble[index]); dpout=~shadow_dp[index].
  - Digit dark (segout all 1 and dpout 1, anode still asserted) if shadow_blank[index]=1.
  - Digit also dark if leading-zero suppressed.
  - Leading-zero suppression: with shadow lz=1, digit k>0 is suppressed when it and every digit above it hold nibble 0. Digit 0 is never suppressed. A lit dp does not stop suppression; the dp is still shown on a suppressed digit.
- Glyphs (segout, a..g, active-low):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- First cycle after Rst deasserts:
  - Prescaler=0, so a dead-time output follows when DEAD_CYC>0.
  - Digit 0 glyph "0" appears on the first non-dead output cycle.
- Rst mid-scan: all outputs dark on the next edge; the scan restarts at digit 0; shadow is cleared.
- Rst and load together: Rst wins.
- Arithmetic:
  - Prescaler width = clog2(REFRESH_DIV); index width = clog2(NUM_DIGITS), minimum 1.
  - No overflow beyond the defined wrap points.

Test Plan:
- (Bench params NUM_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1.) Rst pulse, then load numin=16'h1A2F, lz_en=0 → slot pattern per digit: 1 dark cycle, then 3 cycles lit. anode sequence 1110,1101,1011,0111 repeating. segout sequence 0111000 (F), 0010010 (2), 0001000 (A), 1001111 (1).
- Glyph sweep: for each nibble 0..F, load numin=16'h000n and hold one full slot of digit 0 → segout matches the table for all 16 values.
- Leading zeros: load numin=16'h0040, lz_en=1 → digits 3 and 2 dark with their anode still pulsed; digit 1 shows 1001100; digit 0 shows 0000001. Load numin=16'h0000 → only digit 0 lit, showing "0".
- dp/blank: load dp_in=4'b0100, blank_in=4'b0001 → dpout=0 only during digit 2's lit cycles; digit 0 fully dark. Toggle numin without load → no output change.
- Mid-scan load: load a new value during digit 2's second lit cycle → segout changes on the following cycle; index and prescaler are undisturbed.
- Rst asserted mid-slot on digit 3, with load=1 on the same cycle → next cycle all outputs dark and shadow=0. After release, digit 0 shows "0" at the first lit cycle.
